// File: rtl/phy_rx_deserializer_if.sv
// rtl/phy_rx_deserializer_if.sv - serial input and lane outputs of the phy RX deserializer
//
// Bundles the serial line and the recovered per-lane outputs.
//   in_serial            serial bit stream, MSB of each byte first
//   data_out0..3 [7:0]   recovered byte per lane, held until the next write to that lane
//   valid_out0..3        one-cycle strobe, matching data_outN updated this cycle
//   active               high once the link has locked onto the comma
//   idle_out             one-cycle strobe, an idle comma byte was received while active
// modport slave  : the deserializer (consumes in_serial, drives everything else)
// modport master : the line/driver side (drives in_serial, observes everything else)
interface phy_rx_deserializer_if;
    logic       in_serial;
    logic [7:0] data_out0;
    logic [7:0] data_out1;
    logic [7:0] data_out2;
    logic [7:0] data_out3;
    logic       valid_out0;
    logic       valid_out1;
    logic       valid_out2;
    logic       valid_out3;
    logic       active;
    logic       idle_out;

    modport master (
        output in_serial,
        input  data_out0, data_out1, data_out2, data_out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3,
        input  active, idle_out
    );

    modport slave (
        input  in_serial,
        output data_out0, data_out1, data_out2, data_out3,
        output valid_out0, valid_out1, valid_out2, valid_out3,
        output active, idle_out
    );
endinterface

// File: rtl/phy_rx_deserializer.sv
// rtl/phy_rx_deserializer.sv - serial-to-4-lane deserializer with comma alignment
//
// Hunts bit-by-bit for the BC_BYTE comma, requires SYNC_COUNT consecutive aligned
// commas before going active, then rebuilds bytes and spreads byte slots round-robin
// across four lanes. A comma in a slot means that lane was idle.
// Ports:
//   clk_32f   bit clock, all logic on the rising edge
//   reset     synchronous, active-high
//   rx        phy_rx_deserializer_if.slave (in_serial in; data/valid/active/idle_out out)
module phy_rx_deserializer #(
    parameter logic [7:0]  BC_BYTE    = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic                        clk_32f,
    input  logic                        reset,
    phy_rx_deserializer_if.slave        rx
);

    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] sr;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [3:0] bc_cnt, bc_cnt_next;
    logic [1:0] lane_ptr, lane_ptr_next;

    // Completed byte is registered here first, then written to the lane outputs one
    // edge later: outputs appear on the edge after the one that samples the last bit.
    logic       pend_data, pend_data_next;
    logic       pend_idle, pend_idle_next;
    logic [1:0] pend_lane;
    logic [7:0] pend_byte;

    logic [7:0] data_q [4];
    logic [3:0] valid_q;
    logic       active_q;
    logic       idle_q;

    logic [7:0] rx_byte;
    logic       byte_done;

    assign rx_byte   = {sr[6:0], rx.in_serial};
    assign byte_done = (state != SEARCH) && (bit_cnt == 3'd7);

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        bc_cnt_next    = bc_cnt;
        lane_ptr_next  = lane_ptr;
        pend_data_next = 1'b0;
        pend_idle_next = 1'b0;
        case (state)
            SEARCH: begin
                bit_cnt_next = 3'd0;
                if (rx_byte == BC_BYTE) begin
                    bc_cnt_next   = 4'd1;
                    // The comma just found occupies slot 0, so the next byte is slot 1.
                    lane_ptr_next = 2'd1;
                    state_next    = (SYNC_TARGET == 4'd1) ? ACTIVE : SYNC;
                end
            end
            SYNC: begin
                bit_cnt_next = bit_cnt + 3'd1;
                if (byte_done) begin
                    lane_ptr_next = lane_ptr + 2'd1;
                    if (rx_byte == BC_BYTE) begin
                        if (bc_cnt + 4'd1 >= SYNC_TARGET) begin
                            bc_cnt_next = SYNC_TARGET;
                            state_next  = ACTIVE;
                        end else begin
                            bc_cnt_next = bc_cnt + 4'd1;
                        end
                    end else begin
                        bc_cnt_next = 4'd0;
                        state_next  = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                bit_cnt_next = bit_cnt + 3'd1;
                if (byte_done) begin
                    lane_ptr_next = lane_ptr + 2'd1;
                    if (rx_byte == BC_BYTE) begin
                        pend_idle_next = 1'b1;
                    end else begin
                        pend_data_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            bc_cnt    <= 4'd0;
            lane_ptr  <= 2'd0;
            pend_data <= 1'b0;
            pend_idle <= 1'b0;
            pend_lane <= 2'd0;
            pend_byte <= 8'h00;
            data_q[0] <= 8'h00;
            data_q[1] <= 8'h00;
            data_q[2] <= 8'h00;
            data_q[3] <= 8'h00;
            valid_q   <= 4'b0000;
            active_q  <= 1'b0;
            idle_q    <= 1'b0;
        end else begin
            state     <= state_next;
            sr        <= rx_byte;
            bit_cnt   <= bit_cnt_next;
            bc_cnt    <= bc_cnt_next;
            lane_ptr  <= lane_ptr_next;
            pend_data <= pend_data_next;
            pend_idle <= pend_idle_next;
            pend_lane <= lane_ptr;
            pend_byte <= rx_byte;
            valid_q   <= 4'b0000;
            if (pend_data) begin
                data_q[pend_lane]  <= pend_byte;
                valid_q[pend_lane] <= 1'b1;
            end
            idle_q    <= pend_idle;
            active_q  <= (state == ACTIVE);
        end
    end

    assign rx.data_out0  = data_q[0];
    assign rx.data_out1  = data_q[1];
    assign rx.data_out2  = data_q[2];
    assign rx.data_out3  = data_q[3];
    assign rx.valid_out0 = valid_q[0];
    assign rx.valid_out1 = valid_q[1];
    assign rx.valid_out2 = valid_q[2];
    assign rx.valid_out3 = valid_q[3];
    assign rx.active     = active_q;
    assign rx.idle_out   = idle_q;

endmodule

// File: tb/tb_phy_rx_deserializer.sv
// tb/tb_phy_rx_deserializer.sv - self-checking bench for phy_rx_deserializer
module tb_phy_rx_deserializer;

    localparam logic [7:0] BC = 8'hBC;
    localparam int         SC = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_32f = ~clk_32f;

    phy_rx_deserializer_if bus();

    phy_rx_deserializer #(
        .BC_BYTE    (BC),
        .SYNC_COUNT (SC)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .rx      (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Byte-level line model: a sliding 8-bit window, a bit phase counter once aligned,
    // a count of aligned commas and the slot number of the next byte.
    int  m_cyc   = 0;
    bit  m_live  = 0;
    int  m_mode  = 0;   // 0 hunting, 1 counting commas, 2 locked
    int  m_win   = 0;
    int  m_bits  = 0;
    int  m_count = 0;
    int  m_slot  = 0;
    int  pend_kind = 0; // 0 none, 1 idle, 2 data
    int  pend_lane = 0;
    int  pend_val  = 0;
    logic [7:0] e_data [4];
    logic [3:0] e_valid;
    logic       e_idle;
    logic       e_active;

    // Observations gathered by the compare process
    int vcnt [4];
    int first_data [4];
    int last_data [4];
    int icnt;
    int last_idle_cyc;
    int bad_gap;
    int rise_cyc;
    logic prev_active = 1'b0;

    task automatic model_edge(input bit r, input bit b);
        m_cyc++;
        e_active = (m_mode == 2);
        e_idle   = 1'b0;
        e_valid  = 4'b0000;
        if (pend_kind == 1) begin
            e_idle = 1'b1;
        end else if (pend_kind == 2) begin
            e_valid[pend_lane] = 1'b1;
            e_data[pend_lane]  = 8'(pend_val);
        end
        pend_kind = 0;
        if (r) begin
            m_live = 1; m_mode = 0; m_win = 0; m_bits = 0; m_count = 0; m_slot = 0;
            for (int i = 0; i < 4; i++) e_data[i] = 8'h00;
            e_valid = 4'b0000; e_idle = 1'b0; e_active = 1'b0;
            return;
        end
        m_win = (m_win * 2 + int'(b)) % 256;
        if (m_mode == 0) begin
            if (m_win == int'(BC)) begin
                m_count = 1;
                m_bits  = 0;
                m_slot  = 1;
                m_mode  = (SC == 1) ? 2 : 1;
            end
        end else begin
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                if (m_mode == 1) begin
                    if (m_win == int'(BC)) begin
                        m_count++;
                        if (m_count >= SC) m_mode = 2;
                    end else begin
                        m_count = 0;
                        m_mode  = 0;
                    end
                end else begin
                    if (m_win == int'(BC)) begin
                        pend_kind = 1;
                    end else begin
                        pend_kind = 2;
                        pend_lane = m_slot;
                        pend_val  = m_win;
                    end
                end
                m_slot = (m_slot + 1) % 4;
            end
        end
    endtask

    task automatic send_bit(input bit b);
        bus.in_serial = b;
        reset = 1'b0;
        @(posedge clk_32f);
        model_edge(1'b0, b);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            reset = 1'b1;
            bus.in_serial = ~bus.in_serial;
            @(posedge clk_32f);
            model_edge(1'b1, bus.in_serial);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic peek();
        @(negedge clk_32f);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) begin
            vcnt[i] = 0; first_data[i] = 0; last_data[i] = 0;
        end
        icnt = 0;
        last_idle_cyc = -1;
        bad_gap = 0;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    logic [37:0] got_vec, exp_vec;
    always @(negedge clk_32f) begin
        if (m_live) begin
            got_vec = {bus.data_out0, bus.data_out1, bus.data_out2, bus.data_out3,
                       bus.valid_out0, bus.valid_out1, bus.valid_out2, bus.valid_out3,
                       bus.active, bus.idle_out};
            exp_vec = {e_data[0], e_data[1], e_data[2], e_data[3],
                       e_valid[0], e_valid[1], e_valid[2], e_valid[3],
                       e_active, e_idle};
            checks++;
            if (got_vec !== exp_vec) begin
                errors++;
                $display("FAIL cycle_compare cyc=%0d got=%h expected=%h", m_cyc, got_vec, exp_vec);
            end
            checks++;
            if (!$onehot0({bus.valid_out0, bus.valid_out1, bus.valid_out2, bus.valid_out3, bus.idle_out})) begin
                errors++;
                $display("FAIL strobe_onehot cyc=%0d got=%b expected at most one high", m_cyc,
                         {bus.valid_out0, bus.valid_out1, bus.valid_out2, bus.valid_out3, bus.idle_out});
            end
            if (bus.active === 1'b1 && prev_active !== 1'b1) rise_cyc = m_cyc;
            prev_active = bus.active;
            if (bus.valid_out0) begin vcnt[0]++; if (vcnt[0] == 1) first_data[0] = int'(bus.data_out0); last_data[0] = int'(bus.data_out0); end
            if (bus.valid_out1) begin vcnt[1]++; if (vcnt[1] == 1) first_data[1] = int'(bus.data_out1); last_data[1] = int'(bus.data_out1); end
            if (bus.valid_out2) begin vcnt[2]++; if (vcnt[2] == 1) first_data[2] = int'(bus.data_out2); last_data[2] = int'(bus.data_out2); end
            if (bus.valid_out3) begin vcnt[3]++; if (vcnt[3] == 1) first_data[3] = int'(bus.data_out3); last_data[3] = int'(bus.data_out3); end
            if (bus.idle_out) begin
                if (last_idle_cyc >= 0 && m_cyc - last_idle_cyc != 8) bad_gap++;
                last_idle_cyc = m_cyc;
                icnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before the sequence ended");
        $fatal(1);
    end

    int last_bc;
    initial begin
        bus.in_serial = 1'b0;
        reset = 1'b1;
        rise_cyc = -1;
        clear_counts();

        // T1: reset with the line toggling
        do_reset(3);
        peek();
        check("t1_outputs_zero", int'(|{bus.data_out0, bus.data_out1, bus.data_out2, bus.data_out3,
                                        bus.valid_out0, bus.valid_out1, bus.valid_out2, bus.valid_out3,
                                        bus.idle_out}), 0);
        check("t1_active", int'(bus.active), 0);

        // T2: three junk bits, then four commas
        clear_counts();
        rise_cyc = -1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (4) send_byte(BC);
        last_bc = m_cyc;
        peek();
        check("t2_active_not_yet", int'(bus.active), 0);
        check("t2_no_strobes", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3] + icnt, 0);

        // T3: lane demux starting at lane 0, comma as idle slot, wrap to lane 0
        clear_counts();
        send_byte(8'hA5); send_byte(BC); send_byte(8'h3C); send_byte(8'hFF); send_byte(8'h11);
        send_byte(BC);
        check("t2_active_rise", rise_cyc, last_bc + 1);
        check("t3_lane0_count", vcnt[0], 2);
        check("t3_lane1_count", vcnt[1], 0);
        check("t3_lane2_count", vcnt[2], 1);
        check("t3_lane3_count", vcnt[3], 1);
        check("t3_idle_count", icnt, 1);
        check("t3_lane0_first", first_data[0], 8'hA5);
        check("t3_lane0_wrap", last_data[0], 8'h11);
        check("t3_lane2_data", first_data[2], 8'h3C);
        check("t3_lane3_data", first_data[3], 8'hFF);

        // T4: sync broken by a data byte, then a clean resync
        do_reset(1);
        rise_cyc = -1;
        send_byte(BC); send_byte(BC); send_byte(8'h5A);
        repeat (3) send_byte(BC);
        peek();
        check("t4_not_active_after_3", int'(bus.active), 0);
        send_byte(BC);
        last_bc = m_cyc;

        // T5: sixteen idle commas while active
        clear_counts();
        repeat (16) send_byte(BC);
        send_bit(1'b1);
        peek();
        check("t4_active_rise", rise_cyc, last_bc + 1);
        check("t5_idle_count", icnt, 16);
        check("t5_idle_spacing", bad_gap, 0);
        check("t5_no_valid", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3], 0);

        // T6: reset five bits into a data byte, then resync
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        clear_counts();
        do_reset(1);
        rise_cyc = -1;
        peek();
        check("t6_active_dropped", int'(bus.active), 0);
        repeat (4) send_bit(1'b0);
        check("t6_no_strobes", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3] + icnt, 0);
        repeat (4) send_byte(BC);
        last_bc = m_cyc;
        send_byte(8'h3C);
        send_byte(BC);
        check("t6_active_rise", rise_cyc, last_bc + 1);
        check("t6_lane0_count", vcnt[0], 1);
        check("t6_lane0_data", first_data[0], 8'h3C);

        peek();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
